// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared constants, segment table and slot states for seg_mux_driver
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a} codes, listed from F down to 0
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_e;

    function automatic logic [3:0] digit_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_mux_driver_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Brief    : Combinational nibble to active-low seven-segment decoder
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_SEG_TABLE[nibble_i];
    end

endmodule
`default_nettype wire

// File: rtl/seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_mux_driver
// Brief    : Time-multiplexed 4-digit seven-segment driver with blanking gap,
//            per-frame data capture and leading-zero suppression
// Revision : 1.0 - initial release
// ============================================================================
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    output logic [3:0]  io_sel,
    output logic [7:0]  io_seg,
    output logic        frame_tick
);

    localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    slot_state_e      state_q, state_d;
    logic             start_q;
    logic [15:0]      val_q, val_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       den_q, den_d;
    logic             lz_q, lz_d;
    logic [3:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic             tick_q, tick_d;

    logic             w_wrap;
    logic             w_capture;
    logic [3:0]       w_nibble;
    logic             w_zero_blank;
    logic [6:0]       w_hex_seg;

    hex_to_seg u_hex_to_seg (
        .nibble_i (w_nibble),
        .seg_o    (w_hex_seg)
    );

    // Sequencing: start_q forces the first post-reset cycle to be a capture at digit0/count0
    always_comb begin
        w_wrap    = (cnt_q == CNT_MAX);
        w_capture = start_q || (w_wrap && (dig_q == 2'd3));

        cnt_d = w_wrap ? '0 : cnt_q + 1'b1;
        dig_d = w_wrap ? dig_q + 2'd1 : dig_q;
        if (start_q) begin
            cnt_d = '0;
            dig_d = 2'd0;
        end

        val_d  = val_q;
        dp_d   = dp_q;
        den_d  = den_q;
        lz_d   = lz_q;
        if (w_capture) begin
            val_d = value;
            dp_d  = dp_en;
            den_d = digit_en;
            lz_d  = lz_blank;
        end
        tick_d = w_capture;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_d >= CNT_BLANK) state_d = ON;
            ON:      if (cnt_d < CNT_BLANK)  state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // Outputs are computed from next-state values so the registered pins line up with cnt_q/dig_q
    always_comb begin
        w_nibble     = val_d[3:0];
        w_zero_blank = 1'b0;
        case (dig_d)
            2'd0: begin
                w_nibble     = val_d[3:0];
                w_zero_blank = 1'b0;
            end
            2'd1: begin
                w_nibble     = val_d[7:4];
                w_zero_blank = lz_d && (val_d[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble     = val_d[11:8];
                w_zero_blank = lz_d && (val_d[15:8] == 8'h00);
            end
            default: begin
                w_nibble     = val_d[15:12];
                w_zero_blank = lz_d && (val_d[15:12] == 4'h0);
            end
        endcase

        sel_d = SEL_OFF;
        seg_d = SEG_OFF;
        if ((state_d == ON) && den_d[dig_d]) begin
            sel_d = digit_sel(dig_d);
            seg_d = {~dp_d[dig_d], (w_zero_blank ? 7'h7F : w_hex_seg)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            state_q <= BLANK;
            start_q <= 1'b1;
            val_q   <= 16'h0000;
            dp_q    <= 4'h0;
            den_q   <= 4'h0;
            lz_q    <= 1'b0;
            sel_q   <= SEL_OFF;
            seg_q   <= SEG_OFF;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            state_q <= state_d;
            start_q <= 1'b0;
            val_q   <= val_d;
            dp_q    <= dp_d;
            den_q   <= den_d;
            lz_q    <= lz_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign io_sel     = sel_q;
    assign io_seg     = seg_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_mux_driver
// Brief    : Self-checking bench for seg_mux_driver (REFRESH_DIV=10, BLANK_CYCLES=2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_mux_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_en = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    seg_mux_driver #(
        .REFRESH_DIV  (10),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_en      (dp_en),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .io_sel     (io_sel),
        .io_seg     (io_seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // sel/seg entries are listed digit3 first, digit0 last
    typedef struct packed {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic [3:0]       den;
        logic             lz;
        logic [3:0][3:0]  sel;
        logic [3:0][7:0]  seg;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] v, input logic [3:0] dp,
                               input logic [3:0] den, input logic lz);
        rst      = 1'b1;
        value    = v;
        dp_en    = dp;
        digit_en = den;
        lz_blank = lz;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'h0, 4'hF, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{16'h0005, 4'h0, 4'hF, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
        vecs[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{16'h1234, 4'h0, 4'h5, 1'b0, {4'hF, 4'hB, 4'hF, 4'hE}, {8'hFF, 8'hA4, 8'hFF, 8'h99}};
        vecs[4] = '{16'h8888, 4'h4, 4'hF, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h80, 8'h00, 8'h80, 8'h80}};
        vecs[5] = '{16'h0005, 4'h8, 4'hF, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h7F, 8'hFF, 8'hFF, 8'h92}};
        vecs[6] = '{16'h0100, 4'h0, 4'hF, 1'b1, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hFF, 8'hF9, 8'hC0, 8'hC0}};
        vecs[7] = '{16'hABCD, 4'h0, 4'hF, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h88, 8'h83, 8'hC6, 8'hA1}};
        vecs[8] = '{16'hFE97, 4'h0, 4'hF, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'h8E, 8'h86, 8'h90, 8'hF8}};
        vecs[9] = '{16'h0600, 4'h1, 4'hF, 1'b0, {4'h7, 4'hB, 4'hD, 4'hE}, {8'hC0, 8'h82, 8'hC0, 8'h40}};

        // Asynchronous reset response before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset sel", {4'h0, io_sel}, 8'h0F);
        chk("reset seg", io_seg, 8'hFF);
        chk("reset tick", {7'd0, frame_tick}, 8'h00);

        for (int i = 0; i < 10; i++) begin
            start_frame(vecs[i].value, vecs[i].dp, vecs[i].den, vecs[i].lz);
            for (int k = 0; k < 41; k++) begin
                int         slot;
                int         c;
                logic [3:0] exp_sel;
                logic [7:0] exp_seg;
                step();
                slot    = (k / 10) % 4;
                c       = k % 10;
                exp_sel = (c < 2) ? 4'hF  : vecs[i].sel[slot];
                exp_seg = (c < 2) ? 8'hFF : vecs[i].seg[slot];
                chk($sformatf("v%0d k%0d sel", i, k), {4'h0, io_sel}, {4'h0, exp_sel});
                chk($sformatf("v%0d k%0d seg", i, k), io_seg, exp_seg);
                chk($sformatf("v%0d k%0d tick", i, k), {7'd0, frame_tick},
                    {7'd0, (k % 40) == 0});
            end
        end

        // Mid-frame input change is held off until the next capture
        start_frame(16'h1234, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < 43; k++) begin
            step();
            if (k == 12) value = 16'hABCD;
            if (k == 15) chk("midframe slot1 seg", io_seg, 8'hB0);
            if (k == 25) chk("midframe slot2 seg", io_seg, 8'hA4);
            if (k == 35) chk("midframe slot3 seg", io_seg, 8'hF9);
            if (k == 40) chk("midframe next tick", {7'd0, frame_tick}, 8'h01);
            if (k == 42) begin
                chk("midframe new digit0 seg", io_seg, 8'hA1);
                chk("midframe new digit0 sel", {4'h0, io_sel}, 8'h0E);
            end
        end

        // Reset in the middle of slot2 darkens outputs without a clock edge
        start_frame(16'h1234, 4'h0, 4'hF, 1'b0);
        for (int k = 0; k < 26; k++) step();
        chk("pre-reset seg", io_seg, 8'hA4);
        rst = 1'b1;
        #1;
        chk("midslot reset sel", {4'h0, io_sel}, 8'h0F);
        chk("midslot reset seg", io_seg, 8'hFF);
        chk("midslot reset tick", {7'd0, frame_tick}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        begin
            int ticks;
            ticks = 0;
            for (int k = 0; k < 39; k++) begin
                step();
                if (frame_tick) ticks++;
                if (k == 0) chk("restart tick", {7'd0, frame_tick}, 8'h01);
                if (k == 1) chk("restart blank sel", {4'h0, io_sel}, 8'h0F);
                if (k == 2) begin
                    chk("restart digit0 sel", {4'h0, io_sel}, 8'h0E);
                    chk("restart digit0 seg", io_seg, 8'h99);
                end
            end
            chk("restart tick count", 8'(ticks), 8'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_mux_driver.md
Name: seg_mux_driver

Overview:
Time-multiplexed driver for the 4-digit seven-segment display on the Io board.
It consumes a 16-bit hex value (four nibbles from the counter/datapath) and drives the shared active-low segment bus and active-low digit selects.
It inserts a blanking gap between digits to suppress ghosting.
Display data is captured once per frame, so a digit never shows a mix of old and new values.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2
BLANK_CYCLES, 200, cycles at the start of each slot with all digits off; must be < REFRESH_DIV

Ports:
clk  input  1  100 MHz system clock
rst  input  1  asynchronous reset, active-high
value  input  16  hex digits; value[3:0] = digit0 (rightmost) ... value[15:12] = digit3 (leftmost)
dp_en  input  4  decimal point enable per digit, active-high
digit_en  input  4  digit enable per digit; 0 = digit dark for its whole slot
lz_blank  input  1  1 = suppress leading zeros on digits 3..1
io_sel  output  4  digit select, active-low; io_sel[0] = digit0
io_seg  output  8  segments, active-low; [0]=a ... [6]=g, [7]=dp
frame_tick  output  1  one-cycle pulse when a new frame's data is captured

Behaviour:
- Reset is asynchronous and active-high. Outputs take these values immediately, independent of clk:
  - io_sel=4'hF, io_seg=8'hFF, frame_tick=0
  - slot counter=0, digit index=0, state=BLANK
  - shadow value/dp_en/digit_en/lz_blank = 0
- Slot counter runs 0..REFRESH_DIV-1, then wraps. Its width is clog2(REFRESH_DIV).
- Two-state FSM per slot:
  - BLANK: counter < BLANK_CYCLES. io_sel=4'hF, io_seg=8'hFF.
  - ON: counter >= BLANK_CYCLES. The selected digit is driven.
  - BLANK->ON when the counter reaches BLANK_CYCLES.
  - ON->BLANK on counter wrap. The digit index advances 0->1->2->3->0 on the same wrap.
- Frame capture happens on the first cycle after reset deassertion and on every wrap from digit 3 to digit 0:
  - value, dp_en, digit_en and lz_blank are registered into shadow registers.
  - frame_tick=1 for exactly that cycle.
  - Mid-frame input changes have no visible effect until the next capture.
- All outputs are registered. In the ON phase, io_sel/io_seg reflect shadow data with no combinational path from inputs.
- In ON, for digit index d:
  - If shadow digit_en[d]=0: io_sel=4'hF, io_seg=8'hFF.
  - Otherwise io_sel has only bit d low.
  - io_seg[6:0] = active-low hex code of nibble d.
  - io_seg[7] = ~dp_en[d].
- Leading-zero blanking (shadow lz_blank=1):
  - Digit d (d = 3..1) is blank when nibble d and all higher nibbles are 0.
  - A blank digit drives io_seg[6:0]=7'h7F; the dp is still honoured.
  - Digit0 is never zero-blanked.
- Hex codes (active-low, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Never more than one io_sel bit is low in any cycle. The slot counter never exceeds REFRESH_DIV-1.
- Reset asserted mid-slot: outputs go dark immediately. After release, sequencing restarts at digit0 BLANK with a fresh capture.

Decomposition:
- Package seg_pkg:
  - SEG_OFF=8'hFF, SEL_OFF=4'hF
  - 16-entry active-low hex segment table
  - state enum {BLANK, ON}
- One natural sub-module: hex_to_seg, a combinational nibble -> 7-bit active-low segment decoder, instantiated once on the muxed nibble.

Test Plan:
All scenarios use REFRESH_DIV=10 and BLANK_CYCLES=2.
- value=16'h1234, dp_en=0, digit_en=F, lz_blank=0, after reset -> slot0: cycles 0-1 sel=F/seg=FF, cycles 2-9 sel=E/seg=99; slot1 sel=D/seg=B0; slot2 sel=B/seg=A4; slot3 sel=7/seg=F9; frame_tick every 40 cycles.
- value=16'h0005, lz_blank=1 -> digit0 seg=92; digits 1-3 seg=FF with sel still asserted. value=16'h0000 -> digit0 seg=C0, others FF.
- Change value 16'h1234 -> 16'hABCD during slot1 -> slots 1-3 still show 3,2,1; after next frame_tick, digit0 seg=A1.
- digit_en=4'b0101 -> slots 1 and 3 keep sel=F/seg=FF for all 10 cycles; slots 0 and 2 normal.
- dp_en=4'b0100, value=16'h8888 -> digit2 seg=00, other digits seg=80.
- Assert rst at cycle 5 of slot2 -> same-cycle sel=F/seg=FF without a clk edge; after release, first ON is digit0 and frame_tick pulses once.
